// File: rtl/uart_packetizer_if.sv
// Byte-stream and transmitter-side signals of the UART packetizer.
// The packetizer uses the master modport and its environment uses the slave modport.
interface uart_packetizer_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [9:0]      tx_data;
    logic            start_tx;
    logic            tx_busy;
    logic            tx_ready;
    logic [ADDR_W:0] fifo_count;
    logic            busy;
    logic            overflow;

    modport master (
        input  in_data, in_valid, tx_busy, tx_ready,
        output in_ready, tx_data, start_tx, fifo_count, busy, overflow
    );

    modport slave (
        output in_data, in_valid, tx_busy, tx_ready,
        input  in_ready, tx_data, start_tx, fifo_count, busy, overflow
    );
endinterface

// File: rtl/uart_packetizer.sv
// Buffers incoming bytes in a FIFO and wraps each one into a 10-bit UART frame
// (start, 8 data bits LSB-first, stop) for a transmitter that reads tx_data live.
module uart_packetizer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_packetizer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow_r;
    state_t            state;
    logic [9:0]        tx_data_r;
    logic              start_tx_r;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Full comes from the registered count, so a pop never frees a slot in the same cycle.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (bus.in_valid && full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // tx_data is loaded only on a pop, so it stays put for the whole transmission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_data_r  <= 10'h3FF;
            start_tx_r <= 1'b0;
        end else begin
            start_tx_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data_r <= {1'b1, mem[rd_ptr], 1'b0};
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (bus.tx_ready && !bus.tx_busy) begin
                        start_tx_r <= 1'b1;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !full;
    assign bus.tx_data    = tx_data_r;
    assign bus.start_tx   = start_tx_r;
    assign bus.fifo_count = count;
    assign bus.busy       = (state != IDLE);
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_uart_packetizer.sv
// Self-checking bench for uart_packetizer: a cycle table for single-byte latency,
// plus directed sequences for bursts, overflow, full-FIFO refill, reset and wrap-around.
module tb_uart_packetizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b0;
    int   tx_len = 4;
    int   tx_cnt = 0;

    int total = 0;
    int bad   = 0;

    logic [9:0] rx[$];
    logic [9:0] exp_q[$];
    logic [9:0] cur_frame = 10'h3FF;
    logic       frame_valid = 1'b0;
    logic       prev_start = 1'b0;

    uart_packetizer_if #(.ADDR_W(4)) bus ();

    uart_packetizer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.tx_ready = tx_en && !bus.tx_busy;

    // Transmitter model: busy for tx_len cycles after sampling start_tx.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            tx_cnt      <= 0;
        end else if (bus.start_tx && !bus.tx_busy) begin
            bus.tx_busy <= 1'b1;
            tx_cnt      <= tx_len - 1;
        end else if (bus.tx_busy) begin
            if (tx_cnt == 0) begin
                bus.tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt - 1;
            end
        end
    end

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       tx_en;
        logic [4:0] exp_count;
        logic       exp_in_ready;
        logic [9:0] exp_tx_data;
        logic       exp_start;
        logic       exp_busy;
        logic       exp_overflow;
    } vec_t;

    vec_t vecs[9];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] frameOf(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Records every frame at its start pulse and checks the pulse/hold rules.
    always @(negedge clk) begin
        if (rst) begin
            frame_valid = 1'b0;
            prev_start  = 1'b0;
        end else begin
            if (bus.start_tx) begin
                checkVal("start_single_cycle", 32'(prev_start), 32'(0));
                checkVal("start_while_tx_idle", 32'(bus.tx_busy), 32'(0));
                cur_frame   = bus.tx_data;
                frame_valid = 1'b1;
                rx.push_back(bus.tx_data);
            end else if (bus.tx_busy && frame_valid) begin
                checkVal("tx_data_hold", 32'(bus.tx_data), 32'(cur_frame));
            end
            prev_start = bus.start_tx;
        end
    end

    task automatic applyStimulus(input vec_t v);
        bus.in_valid = v.in_valid;
        bus.in_data  = v.in_data;
        tx_en        = v.tx_en;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkVal({tag, "_count"},    32'(bus.fifo_count), 32'(v.exp_count));
        checkVal({tag, "_in_ready"}, 32'(bus.in_ready),   32'(v.exp_in_ready));
        checkVal({tag, "_tx_data"},  32'(bus.tx_data),    32'(v.exp_tx_data));
        checkVal({tag, "_start_tx"}, 32'(bus.start_tx),   32'(v.exp_start));
        checkVal({tag, "_busy"},     32'(bus.busy),       32'(v.exp_busy));
        checkVal({tag, "_overflow"}, 32'(bus.overflow),   32'(v.exp_overflow));
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_count"},    32'(bus.fifo_count), 32'(0));
        checkVal({tag, "_in_ready"}, 32'(bus.in_ready),   32'(1));
        checkVal({tag, "_tx_data"},  32'(bus.tx_data),    32'(10'h3FF));
        checkVal({tag, "_start_tx"}, 32'(bus.start_tx),   32'(0));
        checkVal({tag, "_busy"},     32'(bus.busy),       32'(0));
        checkVal({tag, "_overflow"}, 32'(bus.overflow),   32'(0));
    endtask

    task automatic pushByte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitFrames(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while ((rx.size() < n || bus.busy || bus.tx_busy || bus.fifo_count != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $display("[TB] FAIL %s_timeout: got %0d frames expected %0d", tag, rx.size(), n);
        end
    endtask

    task automatic checkFrames(input string tag);
        checkVal({tag, "_frame_count"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            checkVal($sformatf("%s_frame%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Single byte 0xA5, transmitter idle: edge N accepts, N+1 pops, N+2 starts.
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 5'd1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 10'h34A, 1'b0, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tx_en        = 1'b1;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("reset");

        $display("[TB] test 1: single byte latency");
        rx.delete();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
        end
        exp_q.delete();
        exp_q.push_back(10'h34A);
        checkFrames("t1");

        $display("[TB] test 2: burst of three");
        rx.delete();
        exp_q.delete();
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            exp_q.push_back(frameOf(8'(i)));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        waitFrames("t2", 3, 300);
        checkFrames("t2");
        checkVal("t2_frame0_const", 32'(exp_q[0]), 32'(10'h202));

        $display("[TB] test 3: fill while transmitter blocked");
        rx.delete();
        exp_q.delete();
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + i);
            exp_q.push_back(frameOf(8'(8'h10 + i)));
            @(posedge clk);
            #1;
        end
        bus.in_data = 8'hFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkVal("t3_count_full", 32'(bus.fifo_count), 32'(16));
        checkVal("t3_in_ready",   32'(bus.in_ready),   32'(0));
        checkVal("t3_overflow",   32'(bus.overflow),   32'(1));

        $display("[TB] test 4: refill on the cycle after a pop");
        bus.in_data = 8'h5A;
        tx_en       = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.fifo_count != 5'd16) break;
        end
        checkVal("t4_pop_count", 32'(bus.fifo_count), 32'(15));
        @(posedge clk);
        #1;
        checkVal("t4_refill_count", 32'(bus.fifo_count), 32'(16));
        bus.in_valid = 1'b0;
        exp_q.push_back(frameOf(8'h5A));
        waitFrames("t4", 18, 800);
        checkFrames("t4");
        checkVal("t4_overflow_sticky", 32'(bus.overflow), 32'(1));

        $display("[TB] test 5: reset during transmission");
        rx.delete();
        tx_len = 12;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h30 + i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkVal("t5_count_before", 32'(bus.fifo_count), 32'(5));
        checkVal("t5_busy_before",  32'(bus.busy),       32'(1));
        checkVal("t5_txbusy_before", 32'(bus.tx_busy),   32'(1));
        rx.delete();
        #2;
        rst = 1'b1;
        #1;
        checkResetState("t5_async");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tx_len = 4;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        checkVal("t5_no_frames", 32'(rx.size()), 32'(0));
        checkVal("t5_busy_after", 32'(bus.busy), 32'(0));
        checkVal("t5_tx_data_after", 32'(bus.tx_data), 32'(10'h3FF));

        $display("[TB] test 6: twenty spaced bytes with pointer wrap");
        rx.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            pushByte(8'(i * 37 + 5));
            exp_q.push_back(frameOf(8'(i * 37 + 5)));
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
        waitFrames("t6", 20, 1000);
        checkFrames("t6");
        checkVal("t6_overflow", 32'(bus.overflow), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
